// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel double-buffered servo PWM generator, optional SERVO_SLEW_EN slew limiting
module servo_pwm_multi #(
  parameter int CLK_HZ    = 50000000,
  parameter int CHANNELS  = 4,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTER_US = 1500,
  parameter int SLEW_STEP = 10,
  localparam int CW       = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [15:0]         wr_data,
  output logic                frame_start,
  output logic [CHANNELS-1:0] pwm_out
);
  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  logic [PW-1:0] pre_cnt;
  logic [15:0]   us_cnt;
  logic [15:0]   pending [CHANNELS];
  logic [15:0]   active  [CHANNELS];
  logic [15:0]   nxt     [CHANNELS];
  logic [15:0]   wr_w;
  logic          en_q;
  logic          tick;
  logic          boundary;
  assign tick     = pre_cnt == PW'(DIV - 1);
  assign boundary = tick && us_cnt == 16'(PERIOD_US - 1);
  assign wr_w     = wr_data < 16'(MIN_US) ? 16'(MIN_US) : wr_data > 16'(MAX_US) ? 16'(MAX_US) : wr_data;
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
`ifdef SERVO_SLEW_EN
      nxt[n] = pending[n] > active[n]
        ? (pending[n] - active[n] > 16'(SLEW_STEP) ? active[n] + 16'(SLEW_STEP) : pending[n])
        : (active[n] - pending[n] > 16'(SLEW_STEP) ? active[n] - 16'(SLEW_STEP) : pending[n]);
`else
      nxt[n] = pending[n];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      us_cnt      <= '0;
      en_q        <= 1'b0;
      frame_start <= 1'b0;
      pwm_out     <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        pending[n] <= 16'(CENTER_US);
        active[n]  <= 16'(CENTER_US);
      end
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
      frame_start <= boundary;
      if (tick)
        us_cnt <= boundary ? 16'd0 : us_cnt + 16'd1;
      if (boundary)
        en_q <= enable;
      for (int n = 0; n < CHANNELS; n++) begin
        pwm_out[n] <= en_q && (us_cnt < active[n]);
        if (boundary)
          active[n] <= nxt[n];
      end
      if (wr_en && 32'(wr_ch) < CHANNELS)
        pending[wr_ch] <= wr_w;
    end
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: randomized frame-level reference check of servo_pwm_multi, optional SERVO_SLEW_EN
module tb_servo_pwm_multi;
  localparam int CLK_HZ = 2000000;
  localparam int NCH    = 4;
  localparam int PER    = 100;
  localparam int MINW   = 10;
  localparam int MAXW   = 50;
  localparam int CEN    = 30;
  localparam int SL     = 5;
  localparam int DIV    = CLK_HZ / 1000000;
  localparam int FR     = PER * DIV;
  logic           clk;
  logic           rst;
  logic           enable;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [15:0]    wr_data;
  logic           frame_start;
  logic [NCH-1:0] pwm_out;
  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;
  int bnd     = 0;
  bit have    = 0;
  bit fen     = 0;
  int pend [NCH];
  int act  [NCH];
  servo_pwm_multi #(
    .CLK_HZ(CLK_HZ), .CHANNELS(NCH), .PERIOD_US(PER), .MIN_US(MINW),
    .MAX_US(MAXW), .CENTER_US(CEN), .SLEW_STEP(SL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .frame_start(frame_start), .pwm_out(pwm_out)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask
  function automatic int clamp(input int d);
    return d < MINW ? MINW : d > MAXW ? MAXW : d;
  endfunction
  function automatic int toward(input int a, input int t);
`ifdef SERVO_SLEW_EN
    int d = t - a;
    if (d > SL) d = SL;
    if (d < -SL) d = -SL;
    return a + d;
`else
    return t;
`endif
  endfunction
  task automatic step();
    logic [NCH-1:0] e;
    logic           fs;
    e  = '0;
    fs = 1'b0;
    @(posedge clk);
    if (rst) begin
      c    = 0;
      have = 0;
      fen  = 0;
      for (int n = 0; n < NCH; n++) begin
        pend[n] = CEN;
        act[n]  = CEN;
      end
    end else begin
      c++;
      fs = (c % FR) == 0;
      for (int n = 0; n < NCH; n++)
        e[n] = have && fen && (c - bnd <= DIV * act[n]);
      if (fs) begin
        for (int n = 0; n < NCH; n++)
          act[n] = toward(act[n], pend[n]);
        fen  = enable;
        bnd  = c;
        have = 1;
      end
      if (wr_en)
        pend[wr_ch] = clamp(int'(wr_data));
    end
    @(negedge clk);
    check("frame_start", frame_start, fs);
    check("pwm", pwm_out, e);
  endtask
  task automatic run(input int k);
    repeat (k) step();
  endtask
  task automatic wr(input int ch, input int d);
    wr_en   = 1;
    wr_ch   = 2'(ch);
    wr_data = 16'(d);
    step();
    wr_en   = 0;
  endtask
  task automatic to_boundary();
    while (c % FR != FR - 1)
      step();
  endtask
  initial begin
    rst     = 1;
    enable  = 0;
    wr_en   = 0;
    wr_ch   = 0;
    wr_data = 0;
    run(3);
    rst    = 0;
    enable = 1;
    run(3 * FR);
    run(40);
    wr(2, 45);
    run(2 * FR);
    wr(0, 5);
    wr(1, 200);
    run(2 * FR);
    to_boundary();
    wr(3, 40);
    run(2 * FR);
    to_boundary();
    run(21);
    enable = 0;
    run(2 * FR);
    enable = 1;
    run(3 * FR);
    wr(0, 0);
    wr(1, 65535);
    run(FR);
    for (int i = 0; i < 40; i++) begin
      run($urandom_range(0, 150));
      if ($urandom_range(0, 5) == 0)
        enable = ~enable;
      if ($urandom_range(0, 4) == 0)
        wr($urandom_range(0, NCH - 1), 65535 - $urandom_range(0, 10));
      else
        wr($urandom_range(0, NCH - 1), $urandom_range(0, 120));
    end
    enable = 1;
    run(2 * FR);
    to_boundary();
    run(1);
    wr(0, 30);
    run(FR);
    wr(0, 50);
    run(6 * FR);
    run(77);
    rst = 1;
    step();
    rst = 0;
    run(3 * FR);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
